// File: rtl/dtcm.sv
// rtl/dtcm.sv - 16 KiB data TCM with byte lanes, misalign detection and sync read.
// Optional DTCM_FWD_EN: same-cycle store data is merged into a load of the same word (write-first).
module dtcm #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  wr_width,
  input  logic [31:0] addr_write,
  input  logic [31:0] write_data,
  input  logic        re,
  input  logic [1:0]  rd_width,
  input  logic [31:0] addr_read,
  output logic [31:0] read_data,
  output logic        misalign_wr,
  output logic        misalign_rd
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] wr_off, rd_off;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [1:0]  wr_boff, rd_boff;
  logic        wr_in, rd_in, wr_mis, rd_mis, wr_ok, rd_ok;
  logic [3:0]  wr_be;
  logic [31:0] wr_lane, rd_word_d;

  logic [31:0] rd_word_q;
  logic [1:0]  rd_off_q, rd_width_q;
  logic        rd_valid_q;
  logic [31:0] rd_mask;

  function automatic logic mis_check(input logic [1:0] width, input logic [1:0] boff);
    case (width)
      2'd0:    return 1'b0;
      2'd1:    return boff[0];
      default: return boff != 2'b00;
    endcase
  endfunction

  always_comb begin
    wr_off  = addr_write - BASE_ADDR;
    rd_off  = addr_read - BASE_ADDR;
    // Offset alone catches below-base addresses via wrap-around; the explicit compare keeps it obvious.
    wr_in   = (addr_write >= BASE_ADDR) && (wr_off < SPAN);
    rd_in   = (addr_read >= BASE_ADDR) && (rd_off < SPAN);
    wr_idx  = wr_off[AW+1:2];
    rd_idx  = rd_off[AW+1:2];
    wr_boff = wr_off[1:0];
    rd_boff = rd_off[1:0];
    wr_mis  = mis_check(wr_width, wr_boff);
    rd_mis  = mis_check(rd_width, rd_boff);
    wr_ok   = we && wr_in && !wr_mis;
    rd_ok   = re && rd_in && !rd_mis;
    case (wr_width)
      2'd0: begin
        wr_be   = 4'b0001 << wr_boff;
        wr_lane = {4{write_data[7:0]}};
      end
      2'd1: begin
        wr_be   = 4'b0011 << wr_boff;
        wr_lane = {2{write_data[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_lane = write_data;
      end
    endcase
  end

  always_comb begin
    rd_word_d = mem[rd_idx];
`ifdef DTCM_FWD_EN
    if (wr_ok && (wr_idx == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) rd_word_d[8*b +: 8] = wr_lane[8*b +: 8];
      end
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_word_q   <= '0;
      rd_off_q    <= '0;
      rd_width_q  <= '0;
      rd_valid_q  <= 1'b0;
      misalign_wr <= 1'b0;
      misalign_rd <= 1'b0;
    end else begin
      misalign_wr <= we && wr_in && wr_mis;
      misalign_rd <= re && rd_in && rd_mis;
      if (re) begin
        rd_word_q  <= rd_word_d;
        rd_off_q   <= rd_boff;
        rd_width_q <= rd_width;
        rd_valid_q <= rd_ok;
      end
    end
  end

  always_comb begin
    case (rd_width_q)
      2'd0:    rd_mask = 32'h0000_00FF;
      2'd1:    rd_mask = 32'h0000_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
    read_data = rd_valid_q ? ((rd_word_q >> {rd_off_q, 3'b000}) & rd_mask) : 32'h0;
  end

endmodule

// File: tb/tb_dtcm.sv
// tb/tb_dtcm.sv - directed self-checking bench for dtcm.
module tb_dtcm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  wr_width = 2'd0;
  logic [31:0] addr_write = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        re = 1'b0;
  logic [1:0]  rd_width = 2'd0;
  logic [31:0] addr_read = 32'h0;
  logic [31:0] read_data;
  logic        misalign_wr, misalign_rd;

  int n_cmp = 0;
  int n_err = 0;

  dtcm dut (
    .clk(clk), .rst(rst),
    .we(we), .wr_width(wr_width), .addr_write(addr_write), .write_data(write_data),
    .re(re), .rd_width(rd_width), .addr_read(addr_read),
    .read_data(read_data), .misalign_wr(misalign_wr), .misalign_rd(misalign_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic op(input logic w, input logic [1:0] ww, input logic [31:0] aw, input logic [31:0] wd,
                    input logic r, input logic [1:0] rw, input logic [31:0] ar);
    we = w; wr_width = ww; addr_write = aw; write_data = wd;
    re = r; rd_width = rw; addr_read = ar;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic st(input logic [1:0] ww, input logic [31:0] aw, input logic [31:0] wd);
    op(1'b1, ww, aw, wd, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic ld(input logic [1:0] rw, input logic [31:0] ar);
    op(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, rw, ar);
  endtask

  task automatic idle();
    op(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_read_data", read_data, 32'h0);
    check("reset_mis_wr", {31'h0, misalign_wr}, 32'h0);
    check("reset_mis_rd", {31'h0, misalign_rd}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    st(2'd2, 32'h1000, 32'hDEADBEEF);
    ld(2'd2, 32'h1000);
    check("word_rt", read_data, 32'hDEADBEEF);
    check("word_rt_mis_wr", {31'h0, misalign_wr}, 32'h0);
    check("word_rt_mis_rd", {31'h0, misalign_rd}, 32'h0);
    idle();
    check("hold_no_re", read_data, 32'hDEADBEEF);

    st(2'd2, 32'h1000, 32'h11223344);
    st(2'd0, 32'h1003, 32'h123456AA);
    ld(2'd2, 32'h1000);
    check("byte_merge_word", read_data, 32'hAA223344);
    ld(2'd0, 32'h1003);
    check("byte_load_3", read_data, 32'h000000AA);
    ld(2'd1, 32'h1002);
    check("short_load_2", read_data, 32'h0000AA22);
    ld(2'd0, 32'h1001);
    check("byte_load_1", read_data, 32'h00000033);

    st(2'd1, 32'h1001, 32'h0000FFFF);
    check("mis_wr_pulse", {31'h0, misalign_wr}, 32'h1);
    idle();
    check("mis_wr_clear", {31'h0, misalign_wr}, 32'h0);
    ld(2'd2, 32'h1000);
    check("mis_wr_no_write", read_data, 32'hAA223344);
    ld(2'd2, 32'h2002);
    check("mis_rd_data", read_data, 32'h0);
    check("mis_rd_pulse", {31'h0, misalign_rd}, 32'h1);
    idle();
    check("mis_rd_clear", {31'h0, misalign_rd}, 32'h0);

    st(2'd2, 32'h1004, 32'h12345678);
    op(1'b1, 2'd1, 32'h1004, 32'h0000BEEF, 1'b1, 2'd2, 32'h1004);
`ifdef DTCM_FWD_EN
    check("same_cycle_fwd", read_data, 32'h1234BEEF);
`else
    check("same_cycle_rf", read_data, 32'h12345678);
`endif
    ld(2'd2, 32'h1004);
    check("after_same_cycle", read_data, 32'h1234BEEF);

    ld(2'd2, 32'h5000);
    check("oor_load_data", read_data, 32'h0);
    check("oor_load_mis", {31'h0, misalign_rd}, 32'h0);
    st(2'd2, 32'h4FFC, 32'hCAFEF00D);
    st(2'd2, 32'h0FFC, 32'h55555555);
    check("oor_store_mis", {31'h0, misalign_wr}, 32'h0);
    st(2'd2, 32'h5000, 32'h66666666);
    ld(2'd2, 32'h4FFC);
    check("top_word_kept", read_data, 32'hCAFEF00D);
    ld(2'd2, 32'h1000);
    check("base_word_kept", read_data, 32'hAA223344);

    ld(2'd2, 32'h1004);
    check("pre_reset_load", read_data, 32'h1234BEEF);
    #2 rst = 1'b1;
    #1;
    check("async_reset_data", read_data, 32'h0);
    #1 rst = 1'b0;
    ld(2'd2, 32'h1004);
    check("post_reset_load", read_data, 32'h1234BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
